// File: rtl/gold_seq_ctrl.sv
// gold_seq_ctrl: seed-fill / chip-run sequencer for one Gold-code LFSR branch.
// Define GOLD_SEQ_REPEAT_EN to add the Repeat input (RUN loops back to FILL for periodic codes).
module gold_seq_ctrl #(
    parameter int cycleA0 = 26,
    parameter int CNT_W   = 16
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic [0:cycleA0-1] Seed,
    input  logic [CNT_W-1:0]   Run_Len,
    input  logic               Stall,
`ifdef GOLD_SEQ_REPEAT_EN
    input  logic               Repeat,
`endif
    output logic               Enable,
    output logic               Fill_En_A,
    output logic               New_Fill_A,
    output logic               Chip_Valid,
    output logic               Busy,
    output logic               Done
);

    localparam int FW = (cycleA0 > 1) ? $clog2(cycleA0) : 1;
    localparam logic [FW-1:0]    LAST_FILL = FW'(cycleA0 - 1);
    localparam logic [FW-1:0]    FILL_ONE  = FW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    state_t             state;
    state_t             state_nx;
    logic [0:cycleA0-1] seed_q;
    logic [CNT_W-1:0]   run_len_q;
    logic [CNT_W-1:0]   ccnt;
    logic [FW-1:0]      fcnt;
    logic [FW-1:0]      fidx;
    logic               fill_last;
    logic               run_last;
    logic               repeat_sel;

    // Seed is shifted in highest index first so stage i ends up holding Seed[i].
    assign fidx      = LAST_FILL - fcnt;
    assign fill_last = (fcnt == LAST_FILL);
    assign run_last  = (ccnt == run_len_q - CNT_ONE);

`ifdef GOLD_SEQ_REPEAT_EN
    assign repeat_sel = Repeat;
`else
    assign repeat_sel = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state     <= IDLE;
            seed_q    <= '0;
            run_len_q <= '0;
            fcnt      <= '0;
            ccnt      <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (Start) begin
                        seed_q    <= Seed;
                        run_len_q <= Run_Len;
                        fcnt      <= '0;
                        ccnt      <= '0;
                    end
                end
                FILL: begin
                    if (!Stall) begin
                        fcnt <= fill_last ? '0 : fcnt + FILL_ONE;
                    end
                end
                RUN: begin
                    // Cleared on the final chip so a repeated pass starts from zero.
                    if (!Stall) begin
                        ccnt <= run_last ? '0 : ccnt + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx   = state;
        Enable     = 1'b0;
        Fill_En_A  = 1'b0;
        New_Fill_A = 1'b0;
        Chip_Valid = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_nx = FILL;
                end
            end
            FILL: begin
                Busy       = 1'b1;
                Fill_En_A  = 1'b1;
                Enable     = ~Stall;
                New_Fill_A = seed_q[fidx];
                if (!Stall && fill_last) begin
                    state_nx = (run_len_q != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                Busy       = 1'b1;
                Enable     = ~Stall;
                Chip_Valid = ~Stall;
                if (!Stall && run_last) begin
                    state_nx = repeat_sel ? FILL : DONE;
                end
            end
            DONE: begin
                Done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gold_seq_ctrl.sv
// tb_gold_seq_ctrl: directed and random stimulus against a queue-of-steps reference model.
// Build with GOLD_SEQ_REPEAT_EN defined to also exercise the Repeat input.
module tb_gold_seq_ctrl;

    localparam int A0 = 26;
    localparam int CW = 16;

    logic          Clock = 1'b0;
    logic          Reset_n;
    logic          Start;
    logic [0:A0-1] Seed;
    logic [CW-1:0] Run_Len;
    logic          Stall;
`ifdef GOLD_SEQ_REPEAT_EN
    logic          Repeat;
    int            repEnd = 0;
`endif
    logic          Enable;
    logic          Fill_En_A;
    logic          New_Fill_A;
    logic          Chip_Valid;
    logic          Busy;
    logic          Done;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    gold_seq_ctrl #(.cycleA0(A0), .CNT_W(CW)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .Seed       (Seed),
        .Run_Len    (Run_Len),
        .Stall      (Stall),
`ifdef GOLD_SEQ_REPEAT_EN
        .Repeat     (Repeat),
`endif
        .Enable     (Enable),
        .Fill_En_A  (Fill_En_A),
        .New_Fill_A (New_Fill_A),
        .Chip_Valid (Chip_Valid),
        .Busy       (Busy),
        .Done       (Done)
    );

    // Reference model: an accepted Start expands into a list of steps (one per fill bit, one per chip);
    // a step is consumed on every unstalled edge, and the last step is followed by a done step.
    typedef struct {
        int   kind;
        logic bitV;
        logic last;
    } step_t;

    step_t         mq[$];
    logic [0:A0-1] mSeed;
    int            mRunLen;
    bit            modelValid = 1'b0;

    function automatic void pushSeq();
        for (int k = 0; k < A0; k++) begin
            mq.push_back('{kind: 1, bitV: mSeed[A0-1-k], last: (k == A0-1) && (mRunLen == 0)});
        end
        for (int c = 0; c < mRunLen; c++) begin
            mq.push_back('{kind: 2, bitV: 1'b0, last: (c == mRunLen-1)});
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [0:A0-1] sd, input logic [CW-1:0] rl,
                                 input logic stl, input logic rstn);
        @(negedge Clock);
        Start   = st;
        Seed    = sd;
        Run_Len = rl;
        Stall   = stl;
        Reset_n = rstn;
    endtask

    // Compare process: check outputs for this cycle, then advance the model across the coming edge.
    always @(negedge Clock) begin
        logic [5:0] exp;
        logic       rep;
        step_t      s;
        #2;
        if (modelValid) begin
            exp = '0;
            if (mq.size() > 0) begin
                case (mq[0].kind)
                    1: exp = {~Stall, 1'b1, mq[0].bitV, 1'b0, 1'b1, 1'b0};
                    2: exp = {~Stall, 1'b0, 1'b0, ~Stall, 1'b1, 1'b0};
                    default: exp = 6'b000001;
                endcase
            end
            checkOutput("outputs{En,FillEn,NewFill,ChipV,Busy,Done}",
                        32'({Enable, Fill_En_A, New_Fill_A, Chip_Valid, Busy, Done}), 32'(exp));
        end
`ifdef GOLD_SEQ_REPEAT_EN
        rep = Repeat;
`else
        rep = 1'b0;
`endif
        if (!Reset_n) begin
            mq.delete();
            modelValid = 1'b1;
        end else if (modelValid) begin
            if (mq.size() == 0) begin
                if (Start) begin
                    mSeed   = Seed;
                    mRunLen = int'(Run_Len);
                    pushSeq();
                end
            end else if (mq[0].kind == 3) begin
                s = mq.pop_front();
            end else if (!Stall) begin
                s = mq.pop_front();
                if (s.last) begin
                    if (s.kind == 2 && rep) pushSeq();
                    else mq.push_back('{kind: 3, bitV: 1'b0, last: 1'b0});
                end
            end
        end
    end

    // One sequence from Start; cycle c is the interval after the c-th edge following the Start edge.
    task automatic runSeq(input logic [0:A0-1] sd, input int rl, input int stA, input int lenA,
                          input int stB, input int lenB, input int intrude, input int rstAt,
                          input int bound, output int doneCyc, output logic [A0-1:0] fbits,
                          output int chips, output logic busyAfter);
        logic st;
        logic stl;
        doneCyc   = -1;
        fbits     = '0;
        chips     = 0;
        busyAfter = 1'b1;
        applyStimulus(1'b1, sd, CW'(rl), 1'b0, 1'b1);
        for (int c = 1; c <= bound && doneCyc < 0; c++) begin
            st  = (c == intrude);
            stl = (c >= stA && c < stA + lenA) || (c >= stB && c < stB + lenB);
            applyStimulus(st, st ? ~sd : sd, st ? CW'(rl + 3) : CW'(rl), stl, (c == rstAt) ? 1'b0 : 1'b1);
`ifdef GOLD_SEQ_REPEAT_EN
            Repeat = (c < repEnd);
`endif
            #3;
            if (Fill_En_A && Enable) fbits = {New_Fill_A, fbits[A0-1:1]};
            if (Chip_Valid) chips++;
            if (Done) doneCyc = c;
            if (c == rstAt + 1) busyAfter = Busy;
        end
        applyStimulus(1'b0, sd, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, sd, '0, 1'b0, 1'b1);
    endtask

    initial begin
        int            dc;
        int            ch;
        logic [A0-1:0] fb;
        logic          ba;
        logic [0:A0-1] base;
        logic [0:A0-1] rs;
        base    = 26'h2AAAAAA;
        Reset_n = 1'b0;
        Start   = 1'b0;
        Seed    = '0;
        Run_Len = '0;
        Stall   = 1'b0;
`ifdef GOLD_SEQ_REPEAT_EN
        Repeat  = 1'b0;
`endif
        $display("[TB] start");
        repeat (3) applyStimulus(1'b1, base, CW'(10), 1'b0, 1'b0);
        #3;
        checkOutput("reset_outputs", 32'({Enable, Fill_En_A, New_Fill_A, Chip_Valid, Busy, Done}), 32'd0);

        runSeq(base, 10, -1, 0, -1, 0, -1, -100, 200, dc, fb, ch, ba);
        checkOutput("base_done_cycle", 32'(dc), 32'd37);
        checkOutput("base_fill_bits", 32'(fb), 32'h2AAAAAA);
        checkOutput("base_chips", 32'(ch), 32'd10);

        runSeq(base, 0, -1, 0, -1, 0, -1, -100, 200, dc, fb, ch, ba);
        checkOutput("zero_len_done_cycle", 32'(dc), 32'd27);
        checkOutput("zero_len_chips", 32'(ch), 32'd0);

        runSeq(base, 10, 6, 3, 34, 2, -1, -100, 200, dc, fb, ch, ba);
        checkOutput("stall_done_cycle", 32'(dc), 32'd42);
        checkOutput("stall_fill_bits", 32'(fb), 32'h2AAAAAA);
        checkOutput("stall_chips", 32'(ch), 32'd10);

        runSeq(base, 10, -1, 0, -1, 0, 13, -100, 200, dc, fb, ch, ba);
        checkOutput("busy_start_fill_bits", 32'(fb), 32'h2AAAAAA);
        checkOutput("busy_start_done_cycle", 32'(dc), 32'd37);

        runSeq(base, 10, -1, 0, -1, 0, -1, 30, 60, dc, fb, ch, ba);
        checkOutput("reset_in_run_busy", 32'(ba), 32'd0);
        checkOutput("reset_in_run_no_done", 32'(dc), 32'hFFFFFFFF);

`ifdef GOLD_SEQ_REPEAT_EN
        repEnd = 31;
        runSeq(base, 4, -1, 0, -1, 0, -1, -100, 200, dc, fb, ch, ba);
        repEnd = 0;
        checkOutput("repeat_done_cycle", 32'(dc), 32'd61);
        checkOutput("repeat_chips", 32'(ch), 32'd8);
`endif

        runSeq(26'h1234567, 65535, -1, 0, -1, 0, -1, -100, 65600, dc, fb, ch, ba);
        checkOutput("max_len_done_cycle", 32'(dc), 32'd65562);
        checkOutput("max_len_chips", 32'(ch), 32'd65535);

        for (int i = 0; i < 3000; i++) begin
            rs = A0'($urandom);
            applyStimulus(($urandom_range(0, 7) == 0), rs,
                          ($urandom_range(0, 9) == 0) ? CW'(0) : CW'($urandom_range(1, 12)),
                          ($urandom_range(0, 4) == 0), ($urandom_range(0, 149) != 0));
`ifdef GOLD_SEQ_REPEAT_EN
            Repeat = ($urandom_range(0, 2) == 0);
`endif
        end
        applyStimulus(1'b0, base, '0, 1'b0, 1'b1);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
